// File: rtl/btn_event_arbiter_pkg.sv
// rtl/btn_event_arbiter_pkg.sv - shared types for the push-button event arbiter
// Purpose: holds the arbiter state encoding used by btn_event_arbiter.
// Ports: none (package).
package btn_event_arbiter_pkg;

  // IDLE: no event presented. HOLD: evt_id is presented with evt_valid=1.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/btn_filter.sv
// rtl/btn_filter.sv - one button channel: 2-flop synchroniser plus stable-time filter
// Purpose: turns one raw bouncy button level into a debounced level and a
//          single-cycle press_accept pulse on each accepted press.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_in       in   raw asynchronous button level, 1 = pressed
//   level        out  debounced stable level
//   press_accept out  high for the cycle in which a 0->1 change is accepted
module btn_filter #(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic press_accept
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The change is taken on the edge where the counter already sits at its
  // last value, so a press is flagged in the same cycle level is updated.
  assign press_accept = (s2 != level) && (cnt == CNT_LAST) && s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      // Any return to the stable level restarts the stability window.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - debounced push-buttons with round-robin press event channel
// Purpose: filters N_BTN raw buttons, records press events per channel and
//          serialises them onto one valid/ready event channel, round-robin.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   [N_BTN] raw button levels, 1 = pressed
//   evt_valid  out  event available on evt_id
//   evt_ready  in   consumer takes the event when evt_valid & evt_ready
//   evt_id     out  [ID_W] index of the button that produced the event
//   btn_level  out  [N_BTN] debounced level per channel
//   btn_toggle out  [N_BTN] flips on every accepted press
//   ovf        out  [N_BTN] sticky: press accepted while previous one still pending
//   ovf_clr    in   synchronous clear of all ovf bits
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter  int N_BTN         = 4,
  parameter  int STABLE_CYCLES = 1000,
  localparam int ID_W          = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_toggle,
  output logic [N_BTN-1:0] ovf,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] ovf_set;
  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  evt_id_nxt;
  logic             pick_hit;
  logic [ID_W-1:0]  pick_idx;
  logic             grant_ok;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in[g]),
      .level       (btn_level[g]),
      .press_accept(press[g])
    );
  end

  // First set request at or after start, wrapping. Walking from the far end
  // down lets the nearest hit overwrite later ones without an early exit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_BTN-1:0] req,
                                            input logic [ID_W-1:0]  start);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (req[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  assign {pick_hit, pick_idx} = rr_pick(pending, ptr);
  assign evt_valid = (state == ARB_HOLD);
  assign grant_ok  = (state == ARB_IDLE) || (evt_valid && evt_ready);

  always_comb begin
    state_nxt  = state;
    evt_id_nxt = evt_id;
    ptr_nxt    = ptr;
    grant_vec  = '0;
    if (grant_ok) begin
      if (pick_hit) begin
        state_nxt           = ARB_HOLD;
        evt_id_nxt          = pick_idx;
        grant_vec[pick_idx] = 1'b1;
        ptr_nxt             = (pick_idx == ID_W'(N_BTN - 1)) ? '0 : pick_idx + ID_W'(1);
      end else begin
        state_nxt = ARB_IDLE;
      end
    end
  end

  // A press landing on the cycle its pending bit is granted re-arms pending
  // without counting as an overflow; otherwise a second press merges.
  assign ovf_set = press & pending & ~grant_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      evt_id     <= '0;
      ptr        <= '0;
      pending    <= '0;
      ovf        <= '0;
      btn_toggle <= '0;
    end else begin
      state      <= state_nxt;
      evt_id     <= evt_id_nxt;
      ptr        <= ptr_nxt;
      pending    <= press | (pending & ~grant_vec);
      ovf        <= ovf_set | (ovf & ~{N_BTN{ovf_clr}});
      btn_toggle <= btn_toggle ^ press;
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] btn_level;
  logic [3:0] btn_toggle;
  logic [3:0] ovf;
  logic       ovf_clr;

  int         n_cmp;
  int         n_err;
  int         cyc;
  int         obs_id[$];
  int         obs_cyc[$];
  int         exp_q[$];
  int         rd_idx;
  logic [3:0] tog_exp;

  btn_event_arbiter #(
    .N_BTN        (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .btn_level (btn_level),
    .btn_toggle(btn_toggle),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every completed handshake; tasks compare against exp_q.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      obs_id.push_back(int'(evt_id));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic test_reset();
    logic bad;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({evt_valid, evt_id, btn_level, btn_toggle, ovf} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async: got %b required 0", {evt_valid, evt_id, btn_level, btn_toggle, ovf});
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if ({evt_valid, evt_id, btn_level, btn_toggle, ovf} !== 15'd0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL reset_quiet: got activity=1 required 0"); end
    n_cmp++;
    if (obs_id.size() != 0) begin n_err++; $display("FAIL reset_no_event: got %0d events required 0", obs_id.size()); end
  endtask

  task automatic test_clean_press();
    @(posedge clk); #1;
    evt_ready = 1'b1;
    btn_in[2] = 1'b1;
    tog_exp[2] = ~tog_exp[2];
    exp_q.push_back(2);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (btn_level[2] !== 1'b0) begin n_err++; $display("FAIL clean_early: got level %b required 0", btn_level[2]); end
    @(posedge clk); #1;
    n_cmp++;
    if (btn_level[2] !== 1'b1) begin n_err++; $display("FAIL clean_level: got %b required 1", btn_level[2]); end
    n_cmp++;
    if (btn_toggle !== tog_exp) begin n_err++; $display("FAIL clean_toggle: got %b required %b", btn_toggle, tog_exp); end
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_err++; $display("FAIL clean_valid_early: got %b required 0", evt_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
      n_err++; $display("FAIL clean_event: got valid %b id %0d required 1 id 2", evt_valid, evt_id);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_err++; $display("FAIL clean_drop: got %b required 0", evt_valid); end
    btn_in[2] = 1'b0;
    repeat (10) @(posedge clk);
    for (int w = 0; w < 60 && ((obs_id.size() - rd_idx) < exp_q.size()); w++) @(posedge clk);
    #1;
    while (rd_idx < obs_id.size() || exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= obs_id.size()) begin
        n_err++; $display("FAIL clean_sb: got no event required id %0d", exp_q[0]); exp_q.delete(0);
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL clean_sb: got id %0d required no event", obs_id[rd_idx]); rd_idx++;
      end else begin
        if (obs_id[rd_idx] != exp_q[0]) begin n_err++; $display("FAIL clean_sb: got id %0d required %0d", obs_id[rd_idx], exp_q[0]); end
        rd_idx++; exp_q.delete(0);
      end
    end
  endtask

  task automatic test_bounce();
    logic bad;
    @(posedge clk); #1;
    bad = 1'b0;
    btn_in[0] = 1'b1;
    tog_exp[0] = ~tog_exp[0];
    exp_q.push_back(0);
    repeat (3) begin @(posedge clk); #1; if (btn_level[0] !== 1'b0) bad = 1'b1; end
    btn_in[0] = 1'b0;
    @(posedge clk); #1; if (btn_level[0] !== 1'b0) bad = 1'b1;
    btn_in[0] = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (btn_level[0] !== 1'b0) bad = 1'b1; end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL bounce_early: got early accept=1 required 0"); end
    @(posedge clk); #1;
    n_cmp++;
    if (btn_level[0] !== 1'b1) begin n_err++; $display("FAIL bounce_level: got %b required 1", btn_level[0]); end
    n_cmp++;
    if (btn_toggle !== tog_exp) begin n_err++; $display("FAIL bounce_toggle: got %b required %b", btn_toggle, tog_exp); end
    btn_in[0] = 1'b0;
    repeat (12) @(posedge clk);
    for (int w = 0; w < 60 && ((obs_id.size() - rd_idx) < exp_q.size()); w++) @(posedge clk);
    #1;
    while (rd_idx < obs_id.size() || exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= obs_id.size()) begin
        n_err++; $display("FAIL bounce_sb: got no event required id %0d", exp_q[0]); exp_q.delete(0);
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL bounce_sb: got id %0d required no event", obs_id[rd_idx]); rd_idx++;
      end else begin
        if (obs_id[rd_idx] != exp_q[0]) begin n_err++; $display("FAIL bounce_sb: got id %0d required %0d", obs_id[rd_idx], exp_q[0]); end
        rd_idx++; exp_q.delete(0);
      end
    end
  endtask

  // first = channel the round-robin pointer is known to point at.
  task automatic test_fairness(input int first);
    int base;
    @(posedge clk); #1;
    evt_ready = 1'b1;
    base = obs_id.size();
    btn_in = 4'hF;
    tog_exp = tog_exp ^ 4'hF;
    for (int k = 0; k < 4; k++) exp_q.push_back((first + k) % 4);
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (btn_toggle !== tog_exp) begin n_err++; $display("FAIL fair_toggle: got %b required %b", btn_toggle, tog_exp); end
    n_cmp++;
    if (obs_id.size() < base + 4) begin
      n_err++; $display("FAIL fair_b2b: got %0d events required 4", obs_id.size() - base);
    end else if (obs_cyc[base + 3] - obs_cyc[base] != 3) begin
      n_err++; $display("FAIL fair_b2b: got span %0d cycles required 3", obs_cyc[base + 3] - obs_cyc[base]);
    end
    btn_in = 4'h0;
    repeat (12) @(posedge clk);
    for (int w = 0; w < 60 && ((obs_id.size() - rd_idx) < exp_q.size()); w++) @(posedge clk);
    #1;
    while (rd_idx < obs_id.size() || exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= obs_id.size()) begin
        n_err++; $display("FAIL fair_sb: got no event required id %0d", exp_q[0]); exp_q.delete(0);
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL fair_sb: got id %0d required no event", obs_id[rd_idx]); rd_idx++;
      end else begin
        if (obs_id[rd_idx] != exp_q[0]) begin n_err++; $display("FAIL fair_sb: got id %0d required %0d", obs_id[rd_idx], exp_q[0]); end
        rd_idx++; exp_q.delete(0);
      end
    end
  endtask

  task automatic test_release_only();
    @(posedge clk); #1;
    evt_ready = 1'b1;
    btn_in[3] = 1'b1;
    tog_exp[3] = ~tog_exp[3];
    exp_q.push_back(3);
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (btn_level[3] !== 1'b1) begin n_err++; $display("FAIL release_setup: got %b required 1", btn_level[3]); end
    btn_in[3] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++;
    if (btn_level[3] !== 1'b1) begin n_err++; $display("FAIL release_early: got %b required 1", btn_level[3]); end
    @(posedge clk); #1;
    n_cmp++;
    if (btn_level[3] !== 1'b0) begin n_err++; $display("FAIL release_level: got %b required 0", btn_level[3]); end
    n_cmp++;
    if (btn_toggle !== tog_exp) begin n_err++; $display("FAIL release_toggle: got %b required %b", btn_toggle, tog_exp); end
    repeat (10) @(posedge clk);
    for (int w = 0; w < 60 && ((obs_id.size() - rd_idx) < exp_q.size()); w++) @(posedge clk);
    #1;
    while (rd_idx < obs_id.size() || exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= obs_id.size()) begin
        n_err++; $display("FAIL release_sb: got no event required id %0d", exp_q[0]); exp_q.delete(0);
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL release_sb: got id %0d required no event", obs_id[rd_idx]); rd_idx++;
      end else begin
        if (obs_id[rd_idx] != exp_q[0]) begin n_err++; $display("FAIL release_sb: got id %0d required %0d", obs_id[rd_idx], exp_q[0]); end
        rd_idx++; exp_q.delete(0);
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    evt_ready = 1'b0;
    btn_in[1] = 1'b1; tog_exp[1] = ~tog_exp[1]; exp_q.push_back(1);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      n_err++; $display("FAIL bp_hold: got valid %b id %0d required 1 id 1", evt_valid, evt_id);
    end
    btn_in[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    btn_in[1] = 1'b1; tog_exp[1] = ~tog_exp[1]; exp_q.push_back(1);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (ovf !== 4'b0000) begin n_err++; $display("FAIL bp_no_ovf: got %b required 0000", ovf); end
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
      n_err++; $display("FAIL bp_stable: got valid %b id %0d required 1 id 1", evt_valid, evt_id);
    end
    btn_in[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    btn_in[1] = 1'b1; tog_exp[1] = ~tog_exp[1];
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (ovf !== 4'b0010) begin n_err++; $display("FAIL bp_ovf: got %b required 0010", ovf); end
    n_cmp++;
    if (btn_toggle !== tog_exp) begin n_err++; $display("FAIL bp_toggle: got %b required %b", btn_toggle, tog_exp); end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    n_cmp++;
    if (ovf !== 4'b0000) begin n_err++; $display("FAIL bp_ovf_clr: got %b required 0000", ovf); end
    btn_in[1] = 1'b0;
    evt_ready = 1'b1;
    repeat (12) @(posedge clk);
    for (int w = 0; w < 60 && ((obs_id.size() - rd_idx) < exp_q.size()); w++) @(posedge clk);
    #1;
    while (rd_idx < obs_id.size() || exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= obs_id.size()) begin
        n_err++; $display("FAIL bp_sb: got no event required id %0d", exp_q[0]); exp_q.delete(0);
      end else if (exp_q.size() == 0) begin
        n_err++; $display("FAIL bp_sb: got id %0d required no event", obs_id[rd_idx]); rd_idx++;
      end else begin
        if (obs_id[rd_idx] != exp_q[0]) begin n_err++; $display("FAIL bp_sb: got id %0d required %0d", obs_id[rd_idx], exp_q[0]); end
        rd_idx++; exp_q.delete(0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    int   base;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    btn_in = 4'b0101;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (evt_valid !== 1'b1 || btn_level !== 4'b0101) begin
      n_err++; $display("FAIL rstmid_setup: got valid %b level %b required 1 0101", evt_valid, btn_level);
    end
    #2; rst_n = 1'b0; #1;
    n_cmp++;
    if ({evt_valid, evt_id, btn_level, btn_toggle, ovf} !== 15'd0) begin
      n_err++; $display("FAIL rstmid_async: got %b required 0", {evt_valid, evt_id, btn_level, btn_toggle, ovf});
    end
    btn_in = 4'b0000;
    tog_exp = 4'b0000;
    base = obs_id.size();
    @(posedge clk); #1;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (evt_valid !== 1'b0 || btn_level !== 4'b0000 || btn_toggle !== tog_exp) bad = 1'b1;
    end
    n_cmp++;
    if (bad || obs_id.size() != base) begin
      n_err++; $display("FAIL rstmid_discard: got leftover activity required none");
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rd_idx    = 0;
    tog_exp   = 4'b0000;
    rst_n     = 1'b1;
    btn_in    = 4'b0000;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_fairness(1);
    test_release_only();
    test_fairness(0);
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
